// File: rtl/card_dealer.sv
// Round sequencer and card source for the bell game: deals two cards per round,
// runs the reaction countdown and holds the result after a decided round.
module card_dealer #(
    parameter logic [15:0] TICK_DIV   = 16'd1000,
    parameter logic [7:0]  COUNT_INIT = 8'd100,
    parameter logic [3:0]  HOLD_TICKS = 4'd3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       finish,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic [7:0] count,
    output logic       card_valid,
    output logic [7:0] round_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAL = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] tick_cnt;
    logic [3:0]  hold_cnt;
    logic        tick_wrap;
    logic [15:0] tick_next;
    logic [3:0]  hold_next;

    assign tick_wrap = (tick_cnt == 16'(TICK_DIV - 16'd1));
    assign tick_next = tick_wrap ? 16'd0 : 16'(tick_cnt + 16'd1);
    assign hold_next = 4'(hold_cnt + 4'd1);

    // Fold a 3-bit raw draw into a card number 1..5.
    function automatic logic [2:0] card_num(input logic [2:0] r);
        logic [2:0] folded;
        folded = (r >= 3'd5) ? 3'(r - 3'd5) : r;
        return 3'(folded + 3'd1);
    endfunction

    // Free-running card source, advances in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Round FSM with registered outputs; stop overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            c1         <= 2'd0;
            c2         <= 2'd0;
            n1         <= 3'd0;
            n2         <= 3'd0;
            count      <= 8'd0;
            card_valid <= 1'b0;
            round_cnt  <= 8'd0;
            busy       <= 1'b0;
            tick_cnt   <= 16'd0;
            hold_cnt   <= 4'd0;
        end else if (stop) begin
            state      <= IDLE;
            c1         <= 2'd0;
            c2         <= 2'd0;
            n1         <= 3'd0;
            n2         <= 3'd0;
            count      <= 8'd0;
            card_valid <= 1'b0;
            round_cnt  <= 8'd0;
            busy       <= 1'b0;
            tick_cnt   <= 16'd0;
            hold_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DEAL;
                        busy  <= 1'b1;
                    end
                end
                DEAL: begin
                    c1         <= lfsr[1:0];
                    c2         <= lfsr[7:6];
                    n1         <= card_num(lfsr[4:2]);
                    n2         <= card_num(lfsr[10:8]);
                    count      <= COUNT_INIT;
                    tick_cnt   <= 16'd0;
                    card_valid <= 1'b1;
                    if (round_cnt != 8'hFF) begin
                        round_cnt <= 8'(round_cnt + 8'd1);
                    end
                    state <= RUN;
                end
                RUN: begin
                    tick_cnt <= tick_next;
                    if (finish) begin
                        // A decided round freezes count even on a wrap edge.
                        state    <= HOLD;
                        hold_cnt <= 4'd0;
                    end else if (tick_wrap) begin
                        if (count != 8'd0) begin
                            count <= 8'(count - 8'd1);
                        end else begin
                            state <= DEAL;
                        end
                    end
                end
                HOLD: begin
                    tick_cnt <= tick_next;
                    if (tick_wrap) begin
                        hold_cnt <= hold_next;
                        if (hold_next == HOLD_TICKS) begin
                            state <= DEAL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer against a round-level behavioural model.
module tb_card_dealer;

    localparam int TICKS  = 4;
    localparam int CINIT  = 10;
    localparam int HOLDT  = 2;
    localparam logic [15:0] SEEDV = 16'hACE1;

    localparam int P_IDLE = 0;
    localparam int P_DEAL = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       finish = 1'b0;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic [7:0] count;
    logic       card_valid;
    logic [7:0] round_cnt;
    logic       busy;

    always #5 clk = ~clk;

    card_dealer #(
        .TICK_DIV  (16'd4),
        .COUNT_INIT(8'd10),
        .HOLD_TICKS(4'd2),
        .SEED      (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .finish    (finish),
        .c1        (c1),
        .c2        (c2),
        .n1        (n1),
        .n2        (n2),
        .count     (count),
        .card_valid(card_valid),
        .round_cnt (round_cnt),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase, clocks since the last deal, and the dealt hand.
    logic [15:0] m_lfsr;
    int m_phase, m_age, m_holds, m_count, m_round, m_deals;
    int m_c1, m_c2, m_n1, m_n2, m_valid;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [15:0] l;
        bit wrap;
        if (rst) begin
            m_lfsr = SEEDV; m_phase = P_IDLE; m_age = 0; m_holds = 0;
            m_count = 0; m_round = 0; m_c1 = 0; m_c2 = 0; m_n1 = 0; m_n2 = 0;
            m_valid = 0;
        end else begin
            l = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            wrap = ((m_age % TICKS) == TICKS - 1);
            if (stop) begin
                m_phase = P_IDLE; m_count = 0; m_round = 0; m_valid = 0;
                m_c1 = 0; m_c2 = 0; m_n1 = 0; m_n2 = 0;
            end else begin
                case (m_phase)
                    P_IDLE: if (start) m_phase = P_DEAL;
                    P_DEAL: begin
                        m_c1 = int'(l[1:0]);
                        m_c2 = int'(l[7:6]);
                        m_n1 = (int'(l[4:2]) % 5) + 1;
                        m_n2 = (int'(l[10:8]) % 5) + 1;
                        m_count = CINIT;
                        m_age = 0;
                        m_round = (m_round < 255) ? m_round + 1 : 255;
                        m_valid = 1;
                        m_deals++;
                        m_phase = P_RUN;
                    end
                    P_RUN: begin
                        m_age++;
                        if (finish) begin
                            m_phase = P_HOLD;
                            m_holds = 0;
                        end else if (wrap) begin
                            if (m_count > 0) m_count--;
                            else m_phase = P_DEAL;
                        end
                    end
                    default: begin
                        m_age++;
                        if (wrap) begin
                            m_holds++;
                            if (m_holds == HOLDT) m_phase = P_DEAL;
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic [3:0] seen_c = 4'd0;
    always @(negedge clk) begin
        if (!rst) begin
            check("c1", 32'(c1), 32'(m_c1));
            check("c2", 32'(c2), 32'(m_c2));
            check("n1", 32'(n1), 32'(m_n1));
            check("n2", 32'(n2), 32'(m_n2));
            check("count", 32'(count), 32'(m_count));
            check("card_valid", 32'(card_valid), 32'(m_valid));
            check("round_cnt", 32'(round_cnt), 32'(m_round));
            check("busy", 32'(busy), 32'(m_phase != P_IDLE));
            if (card_valid) begin
                check("n1_range", 32'(n1 >= 3'd1 && n1 <= 3'd5), 32'd1);
                check("n2_range", 32'(n2 >= 3'd1 && n2 <= 3'd5), 32'd1);
                seen_c[c1] = 1'b1;
                seen_c[c2] = 1'b1;
            end
        end
    end

    task automatic wait_deal(input int prev, input int limit, input string tag);
        int k = 0;
        while (m_deals == prev && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (m_deals == prev) check(tag, 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int k, prev, sel;
        bit saw_zero;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(card_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Start latency and first tick.
        pulse_start();
        check("deal_busy", 32'(busy), 32'd1);
        check("deal_valid", 32'(card_valid), 32'd0);
        @(negedge clk);
        check("first_count", 32'(count), 32'd10);
        check("first_valid", 32'(card_valid), 32'd1);
        check("first_round", 32'(round_cnt), 32'd1);
        repeat (4) @(negedge clk);
        check("first_tick", 32'(count), 32'd9);

        // finish on a wrap edge with count 7.
        k = 0;
        while (!(m_phase == P_RUN && m_count == 7 && (m_age % TICKS) == TICKS - 1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_7", 32'(k < 100), 32'd1);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check("finish_hold", 32'(count), 32'd7);
        repeat (8) @(negedge clk);
        check("hold_count", 32'(count), 32'd7);
        check("hold_round", 32'(round_cnt), 32'd1);
        @(negedge clk);
        check("redeal_count", 32'(count), 32'd10);
        check("redeal_round", 32'(round_cnt), 32'd2);

        // Timeout redeal.
        saw_zero = 1'b0;
        k = 0;
        while (m_round == 2 && k < 100) begin
            @(negedge clk);
            if (count == 8'd0) saw_zero = 1'b1;
            k++;
        end
        check("zero_seen", 32'(saw_zero), 32'd1);
        check("timeout_count", 32'(count), 32'd10);
        check("timeout_round", 32'(round_cnt), 32'd3);

        // stop beats start.
        repeat (3) @(negedge clk);
        stop = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        check("stop_valid", 32'(card_valid), 32'd0);
        check("stop_count", 32'(count), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a RUN cycle.
        pulse_start();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(card_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_round", 32'(round_cnt), 32'd0);
        check("arst_cards", 32'({c1, c2, n1, n2}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized rounds: early finishes, timeouts, occasional stops.
        for (int r = 0; r < 2000; r++) begin
            if (m_phase == P_IDLE) pulse_start();
            k = 0;
            while (m_phase != P_RUN && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (m_phase != P_RUN) check("run_wait", 32'd0, 32'd1);
            prev = m_deals;
            sel = int'($urandom_range(0, 31));
            if (sel == 0 && r < 1500) begin
                stop = 1'b1;
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                stop = 1'b0;
                start = 1'b0;
            end else if (sel < 8) begin
                k = 0;
                while (m_deals == prev && k < 100) begin
                    start = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    k++;
                end
                start = 1'b0;
                if (m_deals == prev) check("timeout_wait", 32'd0, 32'd1);
            end else begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                finish = 1'b1;
                @(negedge clk);
                finish = 1'($urandom_range(0, 1));
                @(negedge clk);
                finish = 1'b0;
                wait_deal(prev, 40, "hold_wait");
            end
        end
        @(negedge clk);
        check("round_sat", 32'(round_cnt), 32'd255);
        check("colours_seen", 32'(seen_c), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
